// File: rtl/dm_present_chain_if.sv
// Handshake/bus bundle between dm_present_chain and its surroundings
// (message source, PRESENT_ENCRYPT core, digest consumer).
// slave modport = chaining controller side; master modport = environment side.
// err_timeout only exists when DM_PRESENT_TIMEOUT_EN is defined.
interface dm_present_chain_if;
  // message input side
  logic         msg_valid;
  logic         msg_ready;
  logic [127:0] msg_block;
  logic         msg_last;
  // PRESENT_ENCRYPT core side
  logic         enc_load;
  logic [63:0]  enc_plaintext;
  logic [127:0] enc_key;
  logic         enc_done;
  logic [63:0]  enc_ciphertext;
  // result / status
  logic [63:0]  digest;
  logic         digest_valid;
  logic         busy;
`ifdef DM_PRESENT_TIMEOUT_EN
  logic         err_timeout;
`endif

  modport slave (
    input  msg_valid, msg_block, msg_last, enc_done, enc_ciphertext,
    output msg_ready, enc_load, enc_plaintext, enc_key, digest, digest_valid, busy
`ifdef DM_PRESENT_TIMEOUT_EN
    , output err_timeout
`endif
  );

  modport master (
    output msg_valid, msg_block, msg_last, enc_done, enc_ciphertext,
    input  msg_ready, enc_load, enc_plaintext, enc_key, digest, digest_valid, busy
`ifdef DM_PRESENT_TIMEOUT_EN
    , input err_timeout
`endif
  );
endinterface

// File: rtl/dm_present_chain.sv
// Purpose: Davies-Meyer chaining controller around PRESENT_ENCRYPT (H <= E_msg(H) xor H).
// Latency: handshake->enc_load 1 cycle; core done edge->H update 2 cycles; digest_valid 1 cycle after UPDATE.
// Backpressure: msg_ready is high only in IDLE; one block in flight, nothing queued.
//
// Ports:
//   clk, reset : system clock, asynchronous active-high reset
//   bus        : dm_present_chain_if.slave (message handshake, core load/key/plaintext,
//                core done/ciphertext, digest/digest_valid, busy[, err_timeout])
// Optional feature macro: DM_PRESENT_TIMEOUT_EN -- bounds the WAIT state to TIMEOUT_CYCLES
// and adds the sticky err_timeout flag (TIMEOUT_CYCLES only exists in that build).
module dm_present_chain #(
  parameter logic [63:0] IV = 64'h0000000000000000
`ifdef DM_PRESENT_TIMEOUT_EN
  ,
  parameter int unsigned TIMEOUT_CYCLES = 64
`endif
) (
  input logic               clk,
  input logic               reset,
  dm_present_chain_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD   = 3'd1,
    S_ARM    = 3'd2,
    S_WAIT   = 3'd3,
    S_UPDATE = 3'd4,
    S_DONE   = 3'd5
  } state_t;

  state_t       r_state;
  logic [63:0]  r_h;           // chaining value
  logic [63:0]  r_cipher;      // ciphertext captured on the done edge
  logic [63:0]  r_plaintext;
  logic [127:0] r_key;
  logic [63:0]  r_digest;
  logic         r_last;
  logic         r_done_q;      // previous enc_done, for edge detection
  logic         r_msg_ready;
  logic         r_enc_load;
  logic         r_digest_valid;
  logic         r_busy;

  logic         w_done_edge;
  logic [63:0]  w_h_next;

  // Only a rising edge counts: a done level left over from the previous
  // operation has already been absorbed into r_done_q by the ARM cycle.
  assign w_done_edge = bus.enc_done && !r_done_q;
  assign w_h_next    = r_cipher ^ r_h;

`ifdef DM_PRESENT_TIMEOUT_EN
  localparam int unsigned        CNT_W    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  logic [CNT_W-1:0] r_wait_cnt;
  logic             r_err_timeout;
  assign bus.err_timeout = r_err_timeout;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state        <= S_IDLE;
      r_h            <= IV;
      r_cipher       <= 64'h0;
      r_plaintext    <= IV;
      r_key          <= 128'h0;
      r_digest       <= 64'h0;
      r_last         <= 1'b0;
      r_done_q       <= 1'b0;
      r_msg_ready    <= 1'b1;
      r_enc_load     <= 1'b0;
      r_digest_valid <= 1'b0;
      r_busy         <= 1'b0;
`ifdef DM_PRESENT_TIMEOUT_EN
      r_wait_cnt     <= '0;
      r_err_timeout  <= 1'b0;
`endif
    end else begin
      r_done_q       <= bus.enc_done;
      // single-cycle pulses, raised only on the transitions below
      r_enc_load     <= 1'b0;
      r_digest_valid <= 1'b0;

      case (r_state)
        S_IDLE: begin
          if (bus.msg_valid && r_msg_ready) begin
            r_key       <= bus.msg_block;
            r_last      <= bus.msg_last;
            r_plaintext <= r_h;
            r_enc_load  <= 1'b1;
            r_msg_ready <= 1'b0;
            r_busy      <= 1'b1;
            r_state     <= S_LOAD;
          end
        end

        S_LOAD: begin
          r_state <= S_ARM;
        end

        S_ARM: begin
`ifdef DM_PRESENT_TIMEOUT_EN
          r_wait_cnt <= '0;
`endif
          r_state <= S_WAIT;
        end

        S_WAIT: begin
          if (w_done_edge) begin
            r_cipher <= bus.enc_ciphertext;
            r_state  <= S_UPDATE;
          end
`ifdef DM_PRESENT_TIMEOUT_EN
          else if (r_wait_cnt == CNT_LAST) begin
            // abandon the message: chain restarts from IV, no digest
            r_err_timeout <= 1'b1;
            r_h           <= IV;
            r_msg_ready   <= 1'b1;
            r_busy        <= 1'b0;
            r_state       <= S_IDLE;
          end else begin
            r_wait_cnt <= r_wait_cnt + 1'b1;
          end
`endif
        end

        S_UPDATE: begin
          r_h <= w_h_next;
          if (r_last) begin
            r_digest       <= w_h_next;
            r_digest_valid <= 1'b1;
            r_state        <= S_DONE;
          end else begin
            r_msg_ready <= 1'b1;
            r_busy      <= 1'b0;
            r_state     <= S_IDLE;
          end
        end

        S_DONE: begin
          r_h         <= IV;
          r_msg_ready <= 1'b1;
          r_busy      <= 1'b0;
          r_state     <= S_IDLE;
        end

        default: begin
          r_msg_ready <= 1'b1;
          r_busy      <= 1'b0;
          r_state     <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.msg_ready     = r_msg_ready;
  assign bus.enc_load      = r_enc_load;
  assign bus.enc_plaintext = r_plaintext;
  assign bus.enc_key       = r_key;
  assign bus.digest        = r_digest;
  assign bus.digest_valid  = r_digest_valid;
  assign bus.busy          = r_busy;

endmodule

// File: tb/tb_dm_present_chain.sv
`timescale 1ns/1ps
module tb_dm_present_chain;

  localparam int ND = 3;

  function automatic logic [63:0] iv_of(input int d);
    case (d)
      1:       iv_of = 64'h4c746e677579656e;
      2:       iv_of = 64'h0123456789abcdef;
      default: iv_of = 64'h0000000000000000;
    endcase
  endfunction

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // bench-driven inputs
  logic         mv  [ND];
  logic         ml  [ND];
  logic [127:0] mb  [ND];
  logic         ed  [ND];
  logic [63:0]  ect [ND];
  // observed outputs
  logic         rdy [ND];
  logic         ld  [ND];
  logic         dv  [ND];
  logic         bsy [ND];
  logic [63:0]  pt  [ND];
  logic [63:0]  dg  [ND];
  logic [127:0] ky  [ND];
`ifdef DM_PRESENT_TIMEOUT_EN
  logic         err [ND];
`endif

  dm_present_chain_if bus [ND] ();

  for (genvar g = 0; g < ND; g++) begin : g_dut
    assign bus[g].msg_valid      = mv[g];
    assign bus[g].msg_last       = ml[g];
    assign bus[g].msg_block      = mb[g];
    assign bus[g].enc_done       = ed[g];
    assign bus[g].enc_ciphertext = ect[g];
    assign rdy[g] = bus[g].msg_ready;
    assign ld[g]  = bus[g].enc_load;
    assign dv[g]  = bus[g].digest_valid;
    assign bsy[g] = bus[g].busy;
    assign pt[g]  = bus[g].enc_plaintext;
    assign dg[g]  = bus[g].digest;
    assign ky[g]  = bus[g].enc_key;
`ifdef DM_PRESENT_TIMEOUT_EN
    assign err[g] = bus[g].err_timeout;
`endif
    dm_present_chain #(.IV(iv_of(g))) u_dut (
      .clk   (clk),
      .reset (rst),
      .bus   (bus[g])
    );
  end

  // ---------------- model: Davies-Meyer chain per DUT ----------------
  logic [63:0]  m_h    [ND];   // chaining value the next load must present
  logic [127:0] m_key  [ND];
  logic [63:0]  m_dig  [ND];   // digest that must be held on the output
  logic         m_pend [ND];   // a digest pulse is owed
  logic [63:0]  m_pv   [ND];
  int           m_loads[ND];   // load pulses owed

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < ND; d++) begin
      m_h[d] = iv_of(d); m_key[d] = '0; m_dig[d] = '0;
      m_pend[d] = 1'b0; m_pv[d] = '0; m_loads[d] = 0;
    end
  endtask

  // one compare process: every cycle, every DUT
  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        for (int d = 0; d < ND; d++) begin
          chk($sformatf("ready_vs_busy[%0d]", d), rdy[d], !bsy[d]);
          if (ld[d]) begin
            chk($sformatf("load_expected[%0d]", d), m_loads[d] > 0, 1);
            if (m_loads[d] > 0) m_loads[d]--;
            chk($sformatf("load_plaintext[%0d]", d), pt[d], m_h[d]);
            chk($sformatf("load_key[%0d]", d), ky[d], m_key[d]);
          end
          if (dv[d]) begin
            chk($sformatf("digest_expected[%0d]", d), m_pend[d], 1);
            chk($sformatf("digest_value[%0d]", d), dg[d], m_pv[d]);
            m_dig[d]  = m_pv[d];
            m_pend[d] = 1'b0;
          end else begin
            chk($sformatf("digest_hold[%0d]", d), dg[d], m_dig[d]);
          end
        end
      end
    end
  end

  // ---------------- stimulus tasks ----------------
  task automatic hs(input int d, input logic [127:0] key, input logic last, input logic [63:0] exp_pt);
    int n;
    m_key[d] = key;
    m_loads[d]++;
    mv[d] = 1'b1; mb[d] = key; ml[d] = last;
    n = 0;
    while (!rdy[d] && n < 100) begin @(posedge clk); #1; n++; end
    chk("handshake_ready_bound", n < 100, 1);
    @(posedge clk); #1;
    mv[d] = 1'b0;
    chk("load_latency", ld[d], 1);
    chk("load_pt_literal", pt[d], exp_pt);
    chk("load_key_literal", ky[d], key);
  endtask

  task automatic send_block(input int d, input logic [127:0] key, input logic last,
                            input logic [63:0] c, input bit stale,
                            input logic [63:0] exp_pt, input logic [63:0] exp_dig);
    if (stale) ed[d] = 1'b1;
    hs(d, key, last, exp_pt);
    if (stale) begin
      repeat (5) begin @(posedge clk); #1; end
      chk("stale_done_ignored", bsy[d], 1);
      ed[d] = 1'b0;
      @(posedge clk); #1;
    end else begin
      repeat (3) begin @(posedge clk); #1; end
    end
    ect[d] = c;
    ed[d]  = 1'b1;
    m_h[d] = c ^ m_h[d];
    if (last) begin
      m_pend[d] = 1'b1;
      m_pv[d]   = m_h[d];
      m_h[d]    = iv_of(d);
    end
    @(posedge clk); #1;
    ed[d] = 1'b0;
    chk("update_busy", bsy[d], 1);
    @(posedge clk); #1;
    if (last) begin
      chk("digest_valid_pulse", dv[d], 1);
      chk("digest_literal", dg[d], exp_dig);
    end else begin
      chk("mid_chain_ready", rdy[d], 1);
      chk("mid_chain_no_digest", dv[d], 0);
    end
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    for (int d = 0; d < ND; d++) begin
      mv[d] = 1'b0; ml[d] = 1'b0; mb[d] = '0; ed[d] = 1'b0; ect[d] = '0;
    end
    model_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;

    // reset release
    for (int d = 0; d < ND; d++) begin
      chk("rst_msg_ready", rdy[d], 1);
      chk("rst_busy", bsy[d], 0);
      chk("rst_digest", dg[d], 0);
      chk("rst_digest_valid", dv[d], 0);
      chk("rst_enc_load", ld[d], 0);
      chk("rst_plaintext", pt[d], iv_of(d));
      chk("rst_key", ky[d], 0);
    end

    // done edge while idle is ignored
    ect[0] = 64'hdeadbeefcafef00d; ed[0] = 1'b1;
    @(posedge clk); #1; ed[0] = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    chk("idle_done_ready", rdy[0], 1);
    chk("idle_done_busy", bsy[0], 0);

    // IV=0 single block: digest equals ciphertext
    send_block(0, 128'h5a5a5a5a_a5a5a5a5_0f0f0f0f_f0f0f0f0, 1'b1, 64'h0123456789abcdef,
               1'b0, 64'h0, 64'h0123456789abcdef);

    // test 1: single block
    send_block(1, 128'h0, 1'b1, 64'h9ead5046c7164e1f, 1'b0,
               64'h4c746e677579656e, 64'hd2d93e21b26f2b71);
    // two-block chain
    send_block(1, 128'h0, 1'b0, 64'h9ead5046c7164e1f, 1'b0,
               64'h4c746e677579656e, 64'h0);
    send_block(1, 128'h0123456789abcdef0123456789abcdef, 1'b1, 64'h1122334455667788, 1'b0,
               64'hd2d93e21b26f2b71, 64'hc3fb0d65e7095cf9);

    // test 2 with a stale done level, then a back-to-back message (msg_valid raised during DONE)
    send_block(2, 128'h0123456789abcdef0123456789abcdef, 1'b1, 64'h0e9d28685e671dd6, 1'b1,
               64'h0123456789abcdef, 64'h0fbe6d0fd7ccd039);
    send_block(2, 128'h0, 1'b1, 64'hffffffffffffffff, 1'b0,
               64'h0123456789abcdef, 64'hfedcba9876543210);

    repeat (4) begin @(posedge clk); #1; end
    for (int d = 0; d < ND; d++) begin
      chk("owed_digest_seen", m_pend[d], 0);
      chk("owed_load_seen", m_loads[d] == 0, 1);
    end

    // reset in the middle of WAIT
    hs(1, 128'hffeeddccbbaa99887766554433221100, 1'b0, 64'h4c746e677579656e);
    repeat (3) begin @(posedge clk); #1; end
    chk("pre_reset_busy", bsy[1], 1);
    rst = 1'b1;
    #1;
    chk("midrst_msg_ready", rdy[1], 1);
    chk("midrst_busy", bsy[1], 0);
    chk("midrst_enc_load", ld[1], 0);
    chk("midrst_digest", dg[1], 0);
    chk("midrst_digest_valid", dv[1], 0);
    chk("midrst_plaintext", pt[1], 64'h4c746e677579656e);
    chk("midrst_key", ky[1], 0);
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;

`ifdef DM_PRESENT_TIMEOUT_EN
    // timeout: done never arrives
    hs(1, 128'h1, 1'b1, 64'h4c746e677579656e);
    repeat (65) begin @(posedge clk); #1; end
    chk("timeout_not_yet", err[1], 0);
    chk("timeout_still_busy", bsy[1], 1);
    @(posedge clk); #1;
    chk("timeout_flag", err[1], 1);
    chk("timeout_ready", rdy[1], 1);
    chk("timeout_digest_kept", dg[1], 0);
    repeat (3) begin @(posedge clk); #1; end
    chk("timeout_sticky", err[1], 1);
    // chain restarted from IV
    send_block(1, 128'h0, 1'b1, 64'h9ead5046c7164e1f, 1'b0,
               64'h4c746e677579656e, 64'hd2d93e21b26f2b71);
`endif

    repeat (3) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
    $fatal(1, "watchdog");
  end

endmodule
